// File: rtl/prog_ctr_seq_if.sv
// Control/status bundle between the test harness and prog_ctr_seq.
// master: harness side, drives Start/StartAddr/Stall/Halt/Branch/Call/Ret/Target
//         and observes PC/Busy/Done/RsErr.
// slave : sequencer side, the mirror image.
interface prog_ctr_seq_if #(
    parameter int unsigned D = 12
);
    logic         Start;
    logic [D-1:0] StartAddr;
    logic         Stall;
    logic         Halt;
    logic         Branch;
    logic         Call;
    logic         Ret;
    logic [D-1:0] Target;
    logic [D-1:0] PC;
    logic         Busy;
    logic         Done;
    logic         RsErr;

    modport master (
        output Start, StartAddr, Stall, Halt, Branch, Call, Ret, Target,
        input  PC, Busy, Done, RsErr
    );

    modport slave (
        input  Start, StartAddr, Stall, Halt, Branch, Call, Ret, Target,
        output PC, Busy, Done, RsErr
    );
endinterface

// File: rtl/prog_ctr_seq.sv
// Program counter and sequencer downstream of the branch-offset LUT.
// Holds the fetch PC, advances it by one per cycle, applies relative
// branches/calls (PC + Target, modulo 2^D), and keeps a small return-address
// stack. Start/Halt/Done form the handshake with the test harness.
// Ports:
//   Clk   - clock, all state updates on the rising edge
//   Reset - synchronous, active-high
//   bus   - prog_ctr_seq_if.slave: control inputs and PC/Busy/Done/RsErr
module prog_ctr_seq #(
    parameter int unsigned D        = 12,
    parameter int unsigned RS_DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    prog_ctr_seq_if.slave    bus
);
    localparam int unsigned AW  = $clog2(RS_DEPTH);
    localparam int unsigned SPW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic [D-1:0]     pc, pc_n;
    logic [SPW-1:0]   sp, sp_n;
    logic             rs_err, rs_err_n;
    logic             busy, done;
    logic             push;
    logic [D-1:0]     pc_inc;
    logic [AW-1:0]    wr_idx, top_idx;
    logic [D-1:0]     stack [RS_DEPTH];

    assign pc_inc  = pc + D'(1);
    assign wr_idx  = AW'(sp);
    assign top_idx = AW'(sp - SPW'(1));

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        sp_n     = sp;
        rs_err_n = rs_err;
        push     = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (bus.Start) begin
                    state_n  = S_RUN;
                    pc_n     = bus.StartAddr;
                    sp_n     = '0;
                    rs_err_n = 1'b0;
                end
            end
            S_RUN: begin
                // Single action per cycle, strict priority order.
                if (bus.Stall) begin
                    state_n = state;
                end else if (bus.Halt) begin
                    state_n = S_DONE;
                end else if (bus.Ret) begin
                    if (sp != '0) begin
                        pc_n = stack[top_idx];
                        sp_n = sp - SPW'(1);
                    end else begin
                        pc_n     = pc_inc;
                        rs_err_n = 1'b1;
                    end
                end else if (bus.Call) begin
                    pc_n = pc + bus.Target;
                    if (sp != SPW'(RS_DEPTH)) begin
                        push = 1'b1;
                        sp_n = sp + SPW'(1);
                    end else begin
                        rs_err_n = 1'b1;
                    end
                end else if (bus.Branch) begin
                    pc_n = pc + bus.Target;
                end else begin
                    pc_n = pc_inc;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= S_IDLE;
            pc     <= '0;
            sp     <= '0;
            rs_err <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            sp     <= sp_n;
            rs_err <= rs_err_n;
            // Status flags get their own flops so they are pure register outputs.
            busy   <= (state_n == S_RUN);
            done   <= (state_n == S_DONE);
        end
    end

    // Stack contents need no reset; SP alone defines validity.
    always_ff @(posedge Clk) begin
        if (!Reset && push) begin
            stack[wr_idx] <= pc_inc;
        end
    end

    assign bus.PC    = pc;
    assign bus.Busy  = busy;
    assign bus.Done  = done;
    assign bus.RsErr = rs_err;
endmodule

// File: tb/tb_prog_ctr_seq.sv
module tb_prog_ctr_seq;
    localparam int unsigned D = 12;

    logic Clk;
    logic Reset;

    prog_ctr_seq_if #(.D(D)) bus ();

    prog_ctr_seq #(.D(D), .RS_DEPTH(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string        tag;
        logic [D-1:0] pc;
        logic         busy;
        logic         done;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Drive one cycle of stimulus, queue the expected post-edge state,
    // then pop and compare after the edge.
    task automatic step(input string tag, input logic rst, input logic st,
                        input logic [D-1:0] sa, input logic stl, input logic hlt,
                        input logic br, input logic cl, input logic rt,
                        input logic [D-1:0] tg, input logic [D-1:0] epc,
                        input logic eb, input logic ed, input logic ee);
        exp_t e;
        Reset         = rst;
        bus.Start     = st;
        bus.StartAddr = sa;
        bus.Stall     = stl;
        bus.Halt      = hlt;
        bus.Branch    = br;
        bus.Call      = cl;
        bus.Ret       = rt;
        bus.Target    = tg;
        e.tag = tag; e.pc = epc; e.busy = eb; e.done = ed; e.err = ee;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".pc"},    32'(bus.PC),    32'(e.pc));
        chk({e.tag, ".busy"},  32'(bus.Busy),  32'(e.busy));
        chk({e.tag, ".done"},  32'(bus.Done),  32'(e.done));
        chk({e.tag, ".rserr"}, 32'(bus.RsErr), 32'(e.err));
    endtask

    initial begin
        Reset = 1'b1;
        bus.Start = 0; bus.StartAddr = '0; bus.Stall = 0; bus.Halt = 0;
        bus.Branch = 0; bus.Call = 0; bus.Ret = 0; bus.Target = '0;
        @(negedge Clk);

        //          tag        rst st sa   stl h br cl rt tg        pc    b d e
        step("reset",          1, 0, 0,   0, 0, 0, 0, 0, 0,        0,    0,0,0);
        step("idle_ignore",    0, 0, 0,   0, 1, 1, 1, 1, 12'd7,    0,    0,0,0);
        // T1
        step("t1_start",       0, 1, 5,   0, 0, 0, 0, 0, 0,        5,    1,0,0);
        step("t1_inc6",        0, 0, 0,   0, 0, 0, 0, 0, 0,        6,    1,0,0);
        step("t1_inc7",        0, 0, 0,   0, 0, 0, 0, 0, 0,        7,    1,0,0);
        step("t1_inc8",        0, 0, 0,   0, 0, 0, 0, 0, 0,        8,    1,0,0);
        step("t1_inc9",        0, 0, 0,   0, 0, 0, 0, 0, 0,        9,    1,0,0);
        // T2
        step("t2_br_to20",     0, 0, 0,   0, 0, 1, 0, 0, 12'd11,   20,   1,0,0);
        step("t2_br_neg17",    0, 0, 0,   0, 0, 1, 0, 0, 12'hFEF,  3,    1,0,0);
        step("t2_br_p11",      0, 0, 0,   0, 0, 1, 0, 0, 12'd11,   14,   1,0,0);
        // T3
        step("t3_br_to30",     0, 0, 0,   0, 0, 1, 0, 0, 12'd16,   30,   1,0,0);
        step("t3_call",        0, 0, 0,   0, 0, 0, 1, 0, 12'd10,   40,   1,0,0);
        step("t3_inc41",       0, 0, 0,   0, 0, 0, 0, 0, 0,        41,   1,0,0);
        step("t3_ret",         0, 0, 0,   0, 0, 0, 0, 1, 0,        31,   1,0,0);
        // T4
        step("t4_br_to9",      0, 0, 0,   0, 0, 1, 0, 0, 12'hFEA,  9,    1,0,0);
        step("t4_ret_empty",   0, 0, 0,   0, 0, 0, 0, 1, 0,        10,   1,0,1);
        step("t4_sticky",      0, 0, 0,   0, 0, 0, 0, 0, 0,        11,   1,0,1);
        step("t4_halt",        0, 0, 0,   0, 1, 0, 0, 0, 0,        11,   0,1,1);
        step("done_ignore",    0, 0, 0,   0, 0, 1, 0, 0, 12'd5,    11,   0,1,1);
        step("restart",        0, 1, 11,  0, 0, 0, 0, 0, 0,        11,   1,0,0);
        step("run_start_ign",  0, 1, 100, 0, 0, 0, 0, 0, 0,        12,   1,0,0);
        // T4b
        step("t4b_call1",      0, 0, 0,   0, 0, 0, 1, 0, 12'd1,    13,   1,0,0);
        step("t4b_call2",      0, 0, 0,   0, 0, 0, 1, 0, 12'd1,    14,   1,0,0);
        step("t4b_call3",      0, 0, 0,   0, 0, 0, 1, 0, 12'd1,    15,   1,0,0);
        step("t4b_call4",      0, 0, 0,   0, 0, 0, 1, 0, 12'd1,    16,   1,0,0);
        step("t4b_call5_ovf",  0, 0, 0,   0, 0, 0, 1, 0, 12'd1,    17,   1,0,1);
        step("t4b_ret1",       0, 0, 0,   0, 0, 0, 0, 1, 0,        16,   1,0,1);
        step("t4b_ret2",       0, 0, 0,   0, 0, 0, 0, 1, 0,        15,   1,0,1);
        step("t4b_ret3",       0, 0, 0,   0, 0, 0, 0, 1, 0,        14,   1,0,1);
        step("t4b_ret4",       0, 0, 0,   0, 0, 0, 0, 1, 0,        13,   1,0,1);
        step("t4b_ret_udf",    0, 0, 0,   0, 0, 0, 0, 1, 0,        14,   1,0,1);
        // Ret outranks Call/Branch
        step("prio_ret_call",  0, 0, 0,   0, 0, 0, 1, 0, 12'd2,    16,   1,0,1);
        step("prio_ret",       0, 0, 0,   0, 0, 1, 1, 1, 12'd9,    15,   1,0,1);
        // T5
        step("t5_br_to50",     0, 0, 0,   0, 0, 1, 0, 0, 12'd35,   50,   1,0,1);
        step("t5_halt_br",     0, 0, 0,   0, 1, 1, 1, 1, 12'd5,    50,   0,1,1);
        step("t5_done_hold",   0, 0, 0,   0, 0, 0, 0, 0, 0,        50,   0,1,1);
        step("t5_start0",      0, 1, 0,   0, 0, 0, 0, 0, 0,        0,    1,0,0);
        // T6
        step("t6_inc1",        0, 0, 0,   0, 0, 0, 0, 0, 0,        1,    1,0,0);
        step("t6_stall1",      0, 0, 0,   1, 0, 1, 0, 0, 12'd7,    1,    1,0,0);
        step("t6_stall2",      0, 0, 0,   1, 0, 1, 0, 0, 12'd7,    1,    1,0,0);
        step("t6_stall3",      0, 0, 0,   1, 1, 1, 0, 1, 12'd7,    1,    1,0,0);
        step("t6_ret_err",     0, 0, 0,   0, 0, 0, 0, 1, 0,        2,    1,0,1);
        step("t6_reset_mid",   1, 0, 0,   0, 0, 1, 0, 0, 12'd7,    0,    0,0,0);
        step("t6_idle_br",     0, 0, 0,   0, 0, 1, 0, 0, 12'd7,    0,    0,0,0);
        step("t6_start_max",   0, 1, 12'd4095, 0, 0, 0, 0, 0, 0,   4095, 1,0,0);
        step("t6_wrap_inc",    0, 0, 0,   0, 0, 0, 0, 0, 0,        0,    1,0,0);
        step("t6_br_wrap",     0, 0, 0,   0, 0, 1, 0, 0, 12'hFFF,  4095, 1,0,0);
        step("t6_self_loop",   0, 0, 0,   0, 0, 1, 0, 0, 12'd0,    4095, 1,0,0);
        step("t6_call_wrap",   0, 0, 0,   0, 0, 0, 1, 0, 12'd2,    1,    1,0,0);
        step("t6_ret_wrap",    0, 0, 0,   0, 0, 0, 0, 1, 0,        0,    1,0,0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
